// File: rtl/oddrx2_tx_pkg.sv
// Shared definitions for the x2 DDR transmit gearbox: FSM states, training nibble,
// and the LEVEL width helper.
package oddrx2_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_TRAIN = 2'd2
    } tx_state_t;

    // Serial 0,1,0,1 when D0 is shifted out first.
    localparam logic [3:0] TRAIN_NIB = 4'b1010;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/oddrx2_tx_fifo.sv
// Small synchronous word FIFO feeding the gearbox; read data is presented
// combinationally from the head entry so a pop and its data land on the same edge.
module oddrx2_tx_fifo
    import oddrx2_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              do_wr;
    logic              do_rd;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/oddrx2_tx_gearbox.sv
// Word-to-nibble gearbox feeding a 4:1 x2 output DDR cell in its SCLK domain.
// Optional link-training burst is compiled in with `define ODDRX2_TX_TRAIN_EN.
module oddrx2_tx_gearbox
    import oddrx2_tx_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 4,
    parameter logic [3:0] IDLE_NIB  = 4'b0000,
    parameter int         TRAIN_LEN = 16
) (
    input  logic                          SCLK,
    input  logic                          RST,
    input  logic [DATA_W-1:0]             IN_DATA,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic                          TRAIN_REQ,
    output logic                          D0,
    output logic                          D1,
    output logic                          D2,
    output logic                          D3,
    output logic                          TX_ACTIVE,
    output logic [level_width(DEPTH)-1:0] LEVEL
);

    localparam int NIB   = DATA_W / 4;
    localparam int LVL_W = level_width(DEPTH);
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    tx_state_t         state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  nib_cnt_reg, nib_cnt_next;
    logic [3:0]        d_reg, d_next;
    logic              active_reg, active_next;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              load_word;
    logic              start_train;
    logic              train_go;

    assign IN_READY = !fifo_full && !RST;

    oddrx2_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk     (SCLK),
        .srst    (RST),
        .wr_en   (IN_VALID && IN_READY),
        .wr_data (IN_DATA),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (LEVEL)
    );

`ifdef ODDRX2_TX_TRAIN_EN
    localparam int TCNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [TCNT_W-1:0] TRAIN_LAST = TCNT_W'(TRAIN_LEN - 1);

    logic              train_pend_reg, train_pend_next;
    logic [TCNT_W-1:0] train_cnt_reg, train_cnt_next;

    // A request arriving on the last nibble of a word counts as pending.
    assign train_go = train_pend_reg || TRAIN_REQ;

    always_comb begin
        train_pend_next = train_pend_reg;
        train_cnt_next  = train_cnt_reg;
        if (start_train) begin
            train_pend_next = 1'b0;
            train_cnt_next  = '0;
        end else begin
            if (state_reg == ST_SEND && TRAIN_REQ) begin
                train_pend_next = 1'b1;
            end
            if (state_reg == ST_TRAIN) begin
                train_cnt_next = train_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            train_pend_reg <= 1'b0;
            train_cnt_reg  <= '0;
        end else begin
            train_pend_reg <= train_pend_next;
            train_cnt_reg  <= train_cnt_next;
        end
    end
`else
    logic unused_train;
    assign unused_train = TRAIN_REQ ^ (TRAIN_LEN > 0);
    assign train_go     = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        nib_cnt_next = nib_cnt_reg;
        d_next       = IDLE_NIB;
        active_next  = 1'b0;
        pop          = 1'b0;
        load_word    = 1'b0;
        start_train  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (train_go) begin
                    start_train = 1'b1;
                end else if (!fifo_empty) begin
                    load_word = 1'b1;
                end
            end
            ST_SEND: begin
                if (nib_cnt_reg != LAST_NIB) begin
                    d_next       = shift_reg[3:0];
                    shift_next   = shift_reg >> 4;
                    nib_cnt_next = nib_cnt_reg + 1'b1;
                    active_next  = 1'b1;
                end else if (train_go) begin
                    start_train = 1'b1;
                end else if (!fifo_empty) begin
                    load_word = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
`ifdef ODDRX2_TX_TRAIN_EN
            ST_TRAIN: begin
                if (train_cnt_reg == TRAIN_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    d_next      = TRAIN_NIB;
                    active_next = 1'b1;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        // Loading drives nibble 0 immediately and keeps the rest for later cycles.
        if (load_word) begin
            pop          = 1'b1;
            d_next       = fifo_rd_data[3:0];
            shift_next   = fifo_rd_data >> 4;
            nib_cnt_next = '0;
            active_next  = 1'b1;
            state_next   = ST_SEND;
        end
        if (start_train) begin
            d_next      = TRAIN_NIB;
            active_next = 1'b1;
            state_next  = ST_TRAIN;
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            nib_cnt_reg <= '0;
            d_reg       <= IDLE_NIB;
            active_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            nib_cnt_reg <= nib_cnt_next;
            d_reg       <= d_next;
            active_reg  <= active_next;
        end
    end

    assign {D3, D2, D1, D0} = d_reg;
    assign TX_ACTIVE        = active_reg;

endmodule

// File: tb/tb_oddrx2_tx_gearbox.sv
// Self-checking bench for oddrx2_tx_gearbox: scoreboard of expected nibbles plus
// per-scenario timing checks; a second instance covers DATA_W=4.
module tb_oddrx2_tx_gearbox;

    localparam logic [3:0] IDLE = 4'h0;
    localparam logic [3:0] TRN  = 4'b1010;

    logic       SCLK = 1'b0;
    logic       RST;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic       TRAIN_REQ;
    logic       D0, D1, D2, D3;
    logic       TX_ACTIVE;
    logic [2:0] LEVEL;
    logic [3:0] dnib;

    logic [3:0] in_data4;
    logic       in_valid4;
    logic       in_ready4;
    logic       train_req4;
    logic       d4_0, d4_1, d4_2, d4_3;
    logic       tx_active4;
    logic [2:0] level4;
    logic [3:0] dnib4;

    int         checks = 0;
    int         passes = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    bit         mon_en = 1'b0;
    bit         prev_active = 1'b0;
    bit         gap_seen = 1'b0;
    int         active_cnt = 0;

    always #5 SCLK = ~SCLK;

    assign dnib  = {D3, D2, D1, D0};
    assign dnib4 = {d4_3, d4_2, d4_1, d4_0};

    oddrx2_tx_gearbox #(
        .DATA_W(8), .DEPTH(4), .IDLE_NIB(4'b0000), .TRAIN_LEN(16)
    ) dut (
        .SCLK(SCLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .TRAIN_REQ(TRAIN_REQ),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .TX_ACTIVE(TX_ACTIVE), .LEVEL(LEVEL)
    );

    oddrx2_tx_gearbox #(
        .DATA_W(4), .DEPTH(4), .IDLE_NIB(4'b0000), .TRAIN_LEN(16)
    ) dut4 (
        .SCLK(SCLK), .RST(RST), .IN_DATA(in_data4), .IN_VALID(in_valid4),
        .IN_READY(in_ready4), .TRAIN_REQ(train_req4),
        .D0(d4_0), .D1(d4_1), .D2(d4_2), .D3(d4_3),
        .TX_ACTIVE(tx_active4), .LEVEL(level4)
    );

    // Scoreboard: every active nibble must match the next expected one.
    always @(negedge SCLK) begin
        if (mon_en && TX_ACTIVE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_extra: got nibble %h, expected none", dnib);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dnib !== mon_exp)
                    $display("FAIL scoreboard_nibble: got %h, expected %h", dnib, mon_exp);
                else
                    passes++;
            end
            $display("tx nibble %h at %0t", dnib, $time);
        end
        if (mon_en && prev_active && TX_ACTIVE !== 1'b1 && exp_q.size() != 0)
            gap_seen = 1'b1;
        prev_active = (TX_ACTIVE === 1'b1);
        if (TX_ACTIVE === 1'b1)
            active_cnt++;
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    // Presents one word and returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [7:0] w);
        bit rdy;
        bit done;
        int n;
        IN_DATA  = w;
        IN_VALID = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            #1;
            rdy = IN_READY;
            @(posedge SCLK);
            #1;
            if (rdy) done = 1'b1;
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance", w);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge SCLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d nibbles outstanding, required 0", name, exp_q.size());
        else
            passes++;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; TRAIN_REQ = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; train_req4 = 1'b0;
        repeat (3) tick();
        @(negedge SCLK);
        checks++; if (dnib !== IDLE) $display("FAIL reset_d: got %h, required %h", dnib, IDLE); else passes++;
        checks++; if (TX_ACTIVE !== 1'b0) $display("FAIL reset_active: got %b, required 0", TX_ACTIVE); else passes++;
        checks++; if (LEVEL !== 3'd0) $display("FAIL reset_level: got %0d, required 0", LEVEL); else passes++;
        checks++; if (IN_READY !== 1'b0) $display("FAIL reset_ready: got %b, required 0", IN_READY); else passes++;
        tick();
        RST = 1'b0;
        @(negedge SCLK);
        checks++; if (IN_READY !== 1'b1) $display("FAIL release_ready: got %b, required 1", IN_READY); else passes++;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        active_cnt = 0;
        exp_q.push_back(4'h5);
        exp_q.push_back(4'hA);
        send_word(8'hA5);
        IN_VALID = 1'b0;
        @(negedge SCLK);
        checks++; if (dnib !== IDLE || TX_ACTIVE !== 1'b0) $display("FAIL single_k: got d=%h act=%b, required d=%h act=0", dnib, TX_ACTIVE, IDLE); else passes++;
        checks++; if (LEVEL !== 3'd1) $display("FAIL single_level: got %0d, required 1", LEVEL); else passes++;
        @(negedge SCLK);
        checks++; if (dnib !== 4'h5 || TX_ACTIVE !== 1'b1) $display("FAIL single_k1: got d=%h act=%b, required d=5 act=1", dnib, TX_ACTIVE); else passes++;
        @(negedge SCLK);
        checks++; if (dnib !== 4'hA || TX_ACTIVE !== 1'b1) $display("FAIL single_k2: got d=%h act=%b, required d=a act=1", dnib, TX_ACTIVE); else passes++;
        @(negedge SCLK);
        checks++; if (dnib !== IDLE || TX_ACTIVE !== 1'b0) $display("FAIL single_k3: got d=%h act=%b, required d=%h act=0", dnib, TX_ACTIVE, IDLE); else passes++;
        repeat (3) @(negedge SCLK);
        checks++; if (active_cnt !== 2) $display("FAIL single_active_cycles: got %0d, required 2", active_cnt); else passes++;
        tick();
    endtask

    task automatic test_burst();
        logic [7:0] words [8];
        words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        active_cnt = 0;
        gap_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(words[i][3:0]);
            exp_q.push_back(words[i][7:4]);
        end
        for (int i = 0; i < 8; i++) begin
            send_word(words[i]);
            if (i == 6) begin
                @(negedge SCLK);
                checks++; if (LEVEL !== 3'd4) $display("FAIL burst_full_level: got %0d, required 4", LEVEL); else passes++;
                checks++; if (IN_READY !== 1'b0) $display("FAIL burst_full_ready: got %b, required 0", IN_READY); else passes++;
            end
        end
        IN_VALID = 1'b0;
        wait_drain("burst");
        repeat (2) @(negedge SCLK);
        checks++; if (gap_seen !== 1'b0) $display("FAIL burst_gap: got gap=%b, required 0", gap_seen); else passes++;
        checks++; if (active_cnt !== 16) $display("FAIL burst_active_cycles: got %0d, required 16", active_cnt); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        send_word(8'hC3);
        send_word(8'h11);
        send_word(8'h22);
        IN_VALID = 1'b0;
        checks++; if (dnib !== 4'hC) $display("FAIL rstmid_nib1: got %h, required c", dnib); else passes++;
        RST = 1'b1;
        tick();
        exp_q.delete();
        @(negedge SCLK);
        checks++; if (dnib !== IDLE || TX_ACTIVE !== 1'b0) $display("FAIL rstmid_d: got d=%h act=%b, required d=%h act=0", dnib, TX_ACTIVE, IDLE); else passes++;
        checks++; if (LEVEL !== 3'd0) $display("FAIL rstmid_level: got %0d, required 0", LEVEL); else passes++;
        checks++; if (IN_READY !== 1'b0) $display("FAIL rstmid_ready: got %b, required 0", IN_READY); else passes++;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge SCLK);
            checks++;
            if (TX_ACTIVE !== 1'b0 || dnib !== IDLE)
                $display("FAIL rstmid_quiet: cycle %0d got d=%h act=%b, required d=%h act=0", i, dnib, TX_ACTIVE, IDLE);
            else
                passes++;
        end
        tick();
    endtask

`ifdef ODDRX2_TX_TRAIN_EN
    task automatic test_train();
        active_cnt = 0;
        exp_q.push_back(4'h0);
        exp_q.push_back(4'hF);
        for (int j = 0; j < 16; j++) exp_q.push_back(TRN);
        exp_q.push_back(4'hC);
        exp_q.push_back(4'h3);
        send_word(8'hF0);
        send_word(8'h3C);
        IN_VALID = 1'b0;
        TRAIN_REQ = 1'b1;
        tick();
        TRAIN_REQ = 1'b0;
        @(negedge SCLK);
        checks++; if (dnib !== 4'hF) $display("FAIL train_word_completes: got %h, required f", dnib); else passes++;
        @(negedge SCLK);
        checks++; if (dnib !== TRN || TX_ACTIVE !== 1'b1) $display("FAIL train_start: got d=%h act=%b, required d=%h act=1", dnib, TX_ACTIVE, TRN); else passes++;
        repeat (4) tick();
        TRAIN_REQ = 1'b1;
        tick();
        TRAIN_REQ = 1'b0;
        wait_drain("train");
        repeat (3) @(negedge SCLK);
        checks++; if (active_cnt !== 20) $display("FAIL train_active_cycles: got %0d, required 20", active_cnt); else passes++;
        tick();
    endtask
`else
    task automatic test_train_ignored();
        active_cnt = 0;
        TRAIN_REQ = 1'b1;
        tick();
        TRAIN_REQ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge SCLK);
            checks++;
            if (dnib !== IDLE || TX_ACTIVE !== 1'b0)
                $display("FAIL train_ignored: cycle %0d got d=%h act=%b, required d=%h act=0", i, dnib, TX_ACTIVE, IDLE);
            else
                passes++;
        end
        tick();
    endtask
`endif

    task automatic test_nib1();
        in_valid4 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            in_data4 = 4'(i);
            @(posedge SCLK);
            #1;
            @(negedge SCLK);
            checks++;
            if (i == 1) begin
                if (dnib4 !== IDLE || tx_active4 !== 1'b0 || level4 !== 3'd1)
                    $display("FAIL nib1_first: got d=%h act=%b lvl=%0d, required d=%h act=0 lvl=1", dnib4, tx_active4, level4, IDLE);
                else
                    passes++;
            end else begin
                if (dnib4 !== 4'(i - 1) || tx_active4 !== 1'b1 || level4 !== 3'd1 || in_ready4 !== 1'b1)
                    $display("FAIL nib1_stream: got d=%h act=%b lvl=%0d rdy=%b, required d=%h act=1 lvl=1 rdy=1", dnib4, tx_active4, level4, in_ready4, 4'(i - 1));
                else
                    passes++;
            end
            $display("nib1 word %h d=%h", 4'(i), dnib4);
        end
        in_valid4 = 1'b0;
        @(negedge SCLK);
        checks++; if (dnib4 !== 4'hF || tx_active4 !== 1'b1) $display("FAIL nib1_last: got d=%h act=%b, required d=f act=1", dnib4, tx_active4); else passes++;
        @(negedge SCLK);
        checks++; if (dnib4 !== IDLE || tx_active4 !== 1'b0 || level4 !== 3'd0) $display("FAIL nib1_end: got d=%h act=%b lvl=%0d, required d=%h act=0 lvl=0", dnib4, tx_active4, level4, IDLE); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_reset_mid();
`ifdef ODDRX2_TX_TRAIN_EN
        test_train();
`else
        test_train_ignored();
`endif
        test_nib1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
